// File: rtl/riscv_div_pkg.sv
// Package for the RV32M divider.
// Holds the operation and FSM state encodings, the default iteration
// count and the divide-by-zero quotient value.
package riscv_div_pkg;

    localparam int          ITER_DEFAULT = 32;
    localparam logic [31:0] DIV0_QUOT    = 32'hFFFFFFFF;

    // Encoding matches op_i: bit 0 = unsigned, bit 1 = remainder
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } div_state_t;

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negate (purely combinational).
// Used both to take operand magnitudes and to restore result signs.
// Ports:
//   a_i   - input value
//   neg_i - 1: output -a_i, 0: output a_i
//   y_o   - result
module div_sign_fix #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic         neg_i,
    output logic [W-1:0] y_o
);

    assign y_o = neg_i ? (~a_i + {{(W-1){1'b0}}, 1'b1}) : a_i;

endmodule

// File: rtl/riscv_div_unit.sv
// Multi-cycle RV32M divider (DIV, DIVU, REM, REMU).
// Radix-2 restoring division, one quotient bit per CALC cycle.
// Divide-by-zero and signed overflow skip CALC and go straight to FIX.
// Ports:
//   clk_i, rst_ni - clock and asynchronous active-low reset
//   start_i       - request, accepted when idle and not killed
//   op_i          - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   rs1_data_i    - dividend
//   rs2_data_i    - divisor
//   rd_addr_i     - destination register index
//   kill_i        - flush; aborts any operation in flight
//   busy_o        - high whenever the FSM is not IDLE
//   done_o        - one-cycle register-file write strobe
//   rd_addr_o     - destination of the completing operation
//   result_o      - quotient or remainder
module riscv_div_unit
    import riscv_div_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ITER = ITER_DEFAULT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            kill_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = $clog2(ITER);

    div_state_t      state_q, state_d;
    div_op_t         op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN:0]   rem_q, rem_d;       // extra bit for borrow detection
    logic [XLEN-1:0] quo_q, quo_d;       // dividend shifts out, quotient shifts in
    logic [XLEN-1:0] dvs_q, dvs_d;       // divisor magnitude
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [4:0]      rd_q, rd_d;
    logic [4:0]      rd_out_q, rd_out_d;
    logic [XLEN-1:0] res_q, res_d;

    // Operand magnitudes
    logic            is_signed;
    logic            s1, s2;
    logic [XLEN-1:0] abs1, abs2;

    assign is_signed = ~op_i[0];
    assign s1        = is_signed & rs1_data_i[XLEN-1];
    assign s2        = is_signed & rs2_data_i[XLEN-1];

    // |0x80000000| stays 0x80000000, which is correct read as unsigned
    div_sign_fix #(.W(XLEN)) u_abs1 (.a_i(rs1_data_i), .neg_i(s1), .y_o(abs1));
    div_sign_fix #(.W(XLEN)) u_abs2 (.a_i(rs2_data_i), .neg_i(s2), .y_o(abs2));

    // Result sign restoration
    logic [XLEN-1:0] quo_fix, rem_fix;

    div_sign_fix #(.W(XLEN)) u_fixq (.a_i(quo_q),            .neg_i(neg_quo_q), .y_o(quo_fix));
    div_sign_fix #(.W(XLEN)) u_fixr (.a_i(rem_q[XLEN-1:0]),  .neg_i(neg_rem_q), .y_o(rem_fix));

    // One restoring step: shift {rem,quo} left, trial-subtract divisor.
    // The wider trial keeps a borrow bit above the full remainder register.
    logic [XLEN+1:0] trial;
    logic            borrow;

    assign trial  = {rem_q, quo_q[XLEN-1]} - {2'b00, dvs_q};
    assign borrow = trial[XLEN+1];

    logic is_div0, is_ovf;

    assign is_div0 = (rs2_data_i == '0);
    assign is_ovf  = is_signed
                   && (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}})
                   && (rs2_data_i == {XLEN{1'b1}});

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rd_d      = rd_q;
        rd_out_d  = rd_out_q;
        res_d     = res_q;

        case (state_q)
            IDLE: begin
                if (start_i && !kill_i) begin
                    op_d = div_op_t'(op_i);
                    rd_d = rd_addr_i;
                    if (is_div0) begin
                        // Results are raw: no sign correction applies
                        quo_d     = DIV0_QUOT;
                        rem_d     = {1'b0, rs1_data_i};
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = FIX;
                    end else if (is_ovf) begin
                        quo_d     = {1'b1, {(XLEN-1){1'b0}}};
                        rem_d     = '0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = FIX;
                    end else begin
                        quo_d     = abs1;
                        dvs_d     = abs2;
                        rem_d     = '0;
                        neg_quo_d = s1 ^ s2;
                        neg_rem_d = s1;
                        cnt_d     = CNT_W'(ITER - 1);
                        state_d   = CALC;
                    end
                end
            end
            CALC: begin
                if (borrow) begin
                    rem_d = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end else begin
                    rem_d = trial[XLEN:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                res_d    = (op_q == REM || op_q == REMU) ? rem_fix : quo_fix;
                rd_out_d = rd_q;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A flush drops the operation without touching the visible outputs
        if (kill_i && state_q != IDLE) begin
            state_d  = IDLE;
            res_d    = res_q;
            rd_out_d = rd_out_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            op_q      <= DIV;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rd_q      <= '0;
            rd_out_q  <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rd_q      <= rd_d;
            rd_out_q  <= rd_out_d;
            res_q     <= res_d;
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == DONE);
    assign rd_addr_o = rd_out_q;
    assign result_o  = res_q;

endmodule

// File: tb/tb_riscv_div_unit.sv
// Directed bench for riscv_div_unit with hand-computed expectations.
module tb_riscv_div_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] rs1_data_i = '0;
    logic [31:0] rs2_data_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        kill_i = 1'b0;
    logic        busy_o, done_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] result_o;

    int checks = 0;
    int failures = 0;

    riscv_div_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .rd_addr_i(rd_addr_i),
        .kill_i(kill_i), .busy_o(busy_o), .done_o(done_o),
        .rd_addr_o(rd_addr_o), .result_o(result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op at cycle 0, watch 40 cycles; optionally raise a
    // competing start at cycle inj_cyc that must be ignored.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp,
                          input int exp_cyc, input int inj_cyc);
        int ndone;
        int dcyc;
        ndone = 0;
        dcyc  = -1;
        start_i = 1'b1; op_i = op; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
        tick();
        start_i = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (done_o) begin
                ndone++;
                dcyc = c;
            end
            if (c == inj_cyc) begin
                start_i = 1'b1; op_i = 2'b01; rs1_data_i = 32'd9; rs2_data_i = 32'd3;
                rd_addr_i = 5'd17;
            end
            tick();
            start_i = 1'b0;
        end
        chk({tag, ".ndone"}, ndone, 1);
        chk({tag, ".cycle"}, dcyc, exp_cyc);
        chk({tag, ".result"}, result_o, exp);
        chk({tag, ".rd"}, {27'd0, rd_addr_o}, {27'd0, rd});
    endtask

    initial begin
        int nd;
        #2;
        chk("rst.busy", {31'd0, busy_o}, 32'd0);
        chk("rst.done", {31'd0, done_o}, 32'd0);
        chk("rst.result", result_o, 32'd0);
        chk("rst.rd", {27'd0, rd_addr_o}, 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();

        run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 34, 0);
        run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd6, 32'd2, 34, 0);
        run_op("div_m7_2",   2'b00, 32'hFFFFFFF9, 32'd2, 5'd1, 32'hFFFFFFFD, 34, 0);
        run_op("rem_m7_2",   2'b10, 32'hFFFFFFF9, 32'd2, 5'd2, 32'hFFFFFFFF, 34, 0);
        run_op("div_7_m2",   2'b00, 32'd7, 32'hFFFFFFFE, 5'd3, 32'hFFFFFFFD, 34, 0);
        run_op("rem_7_m2",   2'b10, 32'd7, 32'hFFFFFFFE, 5'd4, 32'd1, 34, 0);
        run_op("div_min_2",  2'b00, 32'h80000000, 32'd2, 5'd8, 32'hC0000000, 34, 0);
        run_op("divu_big_1", 2'b01, 32'hFFFFFFFF, 32'd1, 5'd0, 32'hFFFFFFFF, 34, 0);
        run_op("divu_5_0",   2'b01, 32'd5, 32'd0, 5'd10, 32'hFFFFFFFF, 2, 0);
        run_op("rem_m5_0",   2'b10, 32'hFFFFFFFB, 32'd0, 5'd11, 32'hFFFFFFFB, 2, 0);
        run_op("div_ovf",    2'b00, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 2, 0);
        run_op("rem_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0, 2, 0);
        run_op("ign_start",  2'b01, 32'd100, 32'd7, 5'd14, 32'd14, 34, 10);

        // Kill at cycle 10: idle at 11, no strobe, outputs untouched
        nd = 0;
        start_i = 1'b1; op_i = 2'b01; rs1_data_i = 32'd100; rs2_data_i = 32'd7; rd_addr_i = 5'd9;
        tick();
        start_i = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (done_o) nd++;
            if (c == 10) kill_i = 1'b1;
            tick();
        end
        kill_i = 1'b0;
        chk("kill.busy", {31'd0, busy_o}, 32'd0);
        chk("kill.ndone", nd, 0);
        chk("kill.result", result_o, 32'd14);
        chk("kill.rd", {27'd0, rd_addr_o}, 32'd14);
        run_op("after_kill", 2'b01, 32'd9, 32'd3, 5'd3, 32'd3, 34, 0);

        // Reset in cycle 20 of an operation
        start_i = 1'b1; op_i = 2'b01; rs1_data_i = 32'd100; rs2_data_i = 32'd7; rd_addr_i = 5'd7;
        tick();
        start_i = 1'b0;
        for (int c = 1; c < 20; c++) tick();
        rst_ni = 1'b0;
        #1;
        chk("mrst.busy", {31'd0, busy_o}, 32'd0);
        chk("mrst.done", {31'd0, done_o}, 32'd0);
        chk("mrst.result", result_o, 32'd0);
        chk("mrst.rd", {27'd0, rd_addr_o}, 32'd0);
        tick();
        rst_ni = 1'b1;
        nd = 0;
        for (int c = 0; c < 40; c++) begin
            if (done_o) nd++;
            tick();
        end
        chk("mrst.ndone", nd, 0);
        chk("mrst.idle", {31'd0, busy_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_div_unit.md
Name: riscv_div_unit

Overview:
- Multi-cycle RV32M divider for DIV, DIVU, REM and REMU.
- Sits between operand read and writeback. It takes rs1/rs2 values read from the register file, plus the destination index.
- After a fixed latency it returns one result, destination index and write strobe. These connect directly to the register file's write_enable_i, write_addr_i and write_data_i.
- Radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- ITER, 32, iterations in CALC; must equal XLEN.

Ports:
- clk_i  input  1  clock; rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- start_i  input  1  request; accepted only in a cycle where busy_o=0 and kill_i=0.
- op_i  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU; sampled on accept.
- rs1_data_i  input  32  dividend; sampled on accept.
- rs2_data_i  input  32  divisor; sampled on accept.
- rd_addr_i  input  5  destination register; sampled on accept.
- kill_i  input  1  pipeline flush; aborts any operation in flight.
- busy_o  output  1  high whenever state != IDLE.
- done_o  output  1  one-cycle write strobe (register file write enable).
- rd_addr_o  output  5  destination register of the completing operation.
- result_o  output  32  quotient or remainder.

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy_o=0, done_o=0, rd_addr_o=0, result_o=0; all internal registers 0.
- States:
  - IDLE: accept when start_i=1 and kill_i=0.
    - Normal case: latch |rs1|/|rs2| (unsigned for DIVU/REMU), operand sign flags, op and rd; go to CALC with cnt=ITER-1.
    - Divide by zero or signed overflow: preload the special result (below) and go directly to FIX.
  - CALC: each cycle shift {rem,quo} left by 1, trial-subtract divisor, set the quotient LSB on no-borrow.
    - Exit to FIX when cnt reaches 0 (exactly 32 CALC cycles); cnt decrements each cycle.
  - FIX: sign correction.
    - Quotient is negated if sign(rs1)^sign(rs2) and the op is signed.
    - Remainder is negated if sign(rs1) and the op is signed.
    - Select quotient or remainder; register result_o and rd_addr_o; go to DONE.
  - DONE: done_o=1 for exactly this cycle; next state IDLE.
- Latency, with the accept cycle as cycle 0:
  - Normal case: CALC in cycles 1–32, FIX in 33, done_o high in cycle 34.
  - Special case: FIX in 1, done_o high in 2.
- Throughput: the next start is accepted at the earliest in cycle 35 (cycle 3 for the special case). start_i while busy_o=1 is ignored and has no effect on the operation in flight.
- Special results:
  - Divisor 0: quotient 0xFFFFFFFF, remainder = rs1 (both signed and unsigned).
  - DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- kill_i:
  - In any non-IDLE state: state goes to IDLE at the next edge, done_o stays 0, and result_o/rd_addr_o keep their previous values.
  - kill_i in DONE: done_o is still 1 in that cycle; the write has already been committed.
  - kill_i with start_i in IDLE: kill wins and no accept occurs.
- result_o and rd_addr_o hold their values after DONE until the next FIX.
- rd_addr_i=0: the operation runs normally and done_o pulses; the register file discards the write to x0.
- Reset mid-operation: immediate return to IDLE; no done_o pulse.
- Width rules:
  - Magnitude path is 32-bit unsigned; remainder register is 33 bits for borrow detection.
  - |0x80000000| = 0x80000000 as unsigned.

Decomposition:
- Package riscv_div_pkg:
  - div_op_t enum (DIV, DIVU, REM, REMU).
  - div_state_t enum (IDLE, CALC, FIX, DONE).
  - Constants ITER_DEFAULT=32 and DIV0_QUOT=32'hFFFFFFFF.
- Single module otherwise. The only natural sub-module is div_sign_fix: combinational conditional two's-complement negate, used for the operand-abs and result-fix paths.

Test Plan:
- DIVU 100/7, rd=5 -> done_o only in cycle 34, result_o=14, rd_addr_o=5; REMU 100/7 -> 2.
- DIV -7/2 (0xFFFFFFF9, 2) -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIV 7/-2 -> 0xFFFFFFFD; REM 7/-2 -> 1.
- DIVU 5/0 -> 0xFFFFFFFF with done_o in cycle 2; REM -5/0 -> 0xFFFFFFFB; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 2; REM of the same operands -> 0.
- Start DIVU 100/7, then start_i=1 with 9/3 in cycle 10 -> second request ignored; only one done_o (cycle 34, result 14).
- Start, kill_i=1 in cycle 10 -> busy_o=0 in cycle 11, no done_o; new DIVU 9/3 accepted in cycle 11 -> done_o in cycle 45, result 3.
- Assert rst_ni=0 in cycle 20 of an operation -> busy_o, done_o, result_o and rd_addr_o are 0 immediately; no done_o after release.
